// File: rtl/multu_seq_if.sv
// Handshake/bus bundle for multu_seq: multu request, HI/LO read port and status.
interface multu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             rd_hi;
  logic             rd_lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             stall;
  logic             done;

  modport master (
    output start, op_a, op_b, rd_hi, rd_lo,
    input  hi, lo, rd_data, busy, stall, done
  );

  modport slave (
    input  start, op_a, op_b, rd_hi, rd_lo,
    output hi, lo, rd_data, busy, stall, done
  );
endinterface

// File: rtl/multu_seq.sv
// Multi-cycle shift-add unsigned multiplier that owns the HI/LO register pair.
// Define MULT_EARLY_TERM_EN to end RUN as soon as no multiplier bits remain.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one shift-add step per cycle, pipeline stalled on multu/mfhi/mflo
// DONE  | product committed, done=1; otherwise behaves as IDLE
module multu_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  multu_seq_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [2*WIDTH-1:0]   prod_step;
  logic                 last_step;

  assign prod_step = mplr_q[0] ? (prod_q + mcand_q) : prod_q;

`ifdef MULT_EARLY_TERM_EN
  // Stop once the bit consumed this step is the last set multiplier bit.
  assign last_step = (cnt_q == CNT_LAST) || ((mplr_q >> 1) == '0);
`else
  assign last_step = (cnt_q == CNT_LAST);
`endif

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          prod_d  = '0;
          mcand_d = {{WIDTH{1'b0}}, bus.op_a};
          mplr_d  = bus.op_b;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        prod_d  = prod_step;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (last_step) begin
          {hi_d, lo_d} = prod_step;
          state_d      = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prod_q  <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.stall   = bus.busy & (bus.start | bus.rd_hi | bus.rd_lo);
  assign bus.rd_data = bus.rd_hi ? hi_q : (bus.rd_lo ? lo_q : '0);
endmodule
